// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default sizing for the CPU memory-port sequencer.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter between fetch and data requesters.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    // grant[0] = fetch, grant[1] = data; on a tie the requester not served last wins
    always_comb begin
        grant = 2'b00;
        if (fetch_req && data_req) begin
            if (owner_t'(last_owner) == OWN_FETCH) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (fetch_req) begin
            grant = 2'b01;
        end else if (data_req) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-port sequencer: arbitrates fetch vs. data, holds the access until
// mem_ready or timeout, captures read data and pulses IR/MDR load strobes.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic              ir_we,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              mdr_we,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_next;
    owner_t           last_owner;
    logic             is_write;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       grant;
    logic             timeout_hit;

    rr_arb2 u_arb (
        .fetch_req  (if_req),
        .data_req   (d_req),
        .last_owner (last_owner),
        .grant      (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_next = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The owner of the current access is by construction the last one served,
    // so a single register serves both the done steering and the arbiter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner <= OWN_FETCH;
            is_write   <= 1'b0;
            wait_cnt   <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        err      <= 1'b0;
                        wait_cnt <= '0;
                        if (grant[1]) begin
                            last_owner <= OWN_DATA;
                            is_write   <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                        end else begin
                            last_owner <= OWN_FETCH;
                            is_write   <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!is_write) begin
                            rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem_en  = (state == ACCESS);
        mem_we  = (state == ACCESS) && is_write;
        if_done = (state == RESP) && (last_owner == OWN_FETCH);
        d_done  = (state == RESP) && (last_owner == OWN_DATA);
        ir_we   = if_done;
        mdr_we  = d_done && !is_write;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer and arbiter for the single memory port of the multi-cycle CPU. It shares the port between the instruction-fetch requester and the data load/store requester, and inserts wait states until the memory answers. It holds address, write data and direction stable for the whole access, and captures read data. It generates the one-cycle load strobes for the IR (fetch) and the MDR (data read), and flags accesses that time out.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready before abort (1..255)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse, fetch complete
- ir_we  out  1  one-cycle IR load strobe, coincident with if_done
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse, data access complete
- mdr_we  out  1  one-cycle MDR load strobe, loads only, coincident with d_done
- rdata  out  DATA_W  registered read data, valid from the done cycle until the next read completes
- err  out  1  timeout flag for the access just completed; valid with done and held until the next grant
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the access this cycle

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any request is present, arbitrate and register the winner's address, write data and direction.
  - Set owner, clear err, clear wait counter, go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration** is two-way round robin on last_owner.
  - Single request: that request wins.
  - Both requests: the one not served last wins.
  - last_owner updates at grant.
  - last_owner resets to FETCH, so data wins the first tie.
- **ACCESS**
  - mem_en=1; mem_we=1 only for a data store.
  - mem_addr and mem_wdata are stable for the whole state.
  - mem_ready=1: if the access is a read, capture mem_rdata into rdata. Go to RESP.
  - Otherwise, counter++. When the counter reaches TIMEOUT-1 without ready, set err=1 and go to RESP. rdata is left unchanged.
- **RESP**
  - Pulse done for owner.
  - Pulse ir_we (fetch) or mdr_we (data load, also on timeout).
  - mem_en=0. Go to IDLE.
- **Request rules**
  - Requesters hold req and request fields until done.
  - A req dropped during ACCESS does not cancel the access; it completes.
  - The controller samples req again in IDLE. A requester still holding req after done starts a new access.
  - Fetch is always a read; no write path exists from fetch.

## Timing
- Zero wait states:
  - req seen in IDLE at cycle 0, ACCESS in cycle 1 with mem_ready=1, done/strobe in cycle 2.
  - Back-to-back period is 3 cycles.
- N wait states: done in cycle 2+N.
- Timeout: done with err=1 in cycle 1+TIMEOUT.
- mem_ready outside ACCESS is ignored.
- Reset values: state=IDLE, last_owner=FETCH, counter=0.
  - All outputs 0, including rdata, mem_addr, mem_wdata and err.
- Reset mid-access: next cycle is IDLE.
  - No done pulse, mem_en drops immediately.
  - The requester must re-issue.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- Package mem_ctrl_pkg:
  - state_t enum {IDLE, ACCESS, RESP}
  - owner_t {OWN_FETCH=0, OWN_DATA=1}
  - default width/TIMEOUT constants
- Sub-module rr_arb2:
  - inputs: two requests, last_owner
  - outputs: one-hot grant
  - combinational, instantiated once
- FSM, counter and datapath registers stay in mem_access_ctrl.

## Test plan
- **Fetch, no wait:** if_req, if_addr=0x0000_0004, mem_ready=1 in first ACCESS cycle, mem_rdata=0x8C01_0008.
  - Expect if_done and ir_we in cycle 2 and rdata=0x8C01_0008.
  - Expect mdr_we=0 and mem_we=0 throughout.
- **Store with waits:** d_req, d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D, mem_ready after 3 wait cycles.
  - Expect mem_we=1 with stable addr/data for 4 ACCESS cycles.
  - Expect d_done in cycle 5, mdr_we=0, rdata unchanged.
- **Tie arbitration:** if_req and d_req both asserted from reset and held.
  - Expect grants to alternate data, fetch, data.
  - Expect each done to arrive only for the owner.
- **Timeout:** d_req load, mem_ready never, TIMEOUT=15.
  - Expect d_done and mdr_we in cycle 16 with err=1.
  - Expect err=0 after the next grant.
- **Reset mid-access:** rst_n=0 during the second wait cycle.
  - Expect IDLE next cycle, all outputs 0, no done pulse.
  - Expect a fresh request afterwards to complete normally.
- **Dropped request:** if_req deasserted during ACCESS.
  - Expect the access to complete with if_done.
  - Expect no further grant while if_req=0.
